// File: rtl/inst_fetch_queue.sv
// Instruction FIFO between IF and ID: valid/ready on both sides, flush on redirect,
// and a misaligned-fetch (AdEL) tag carried with every stored word.
module inst_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [31:0]   in_pc,
  input  logic [31:0]   in_inst,
  output logic          in_ready,
  input  logic          flush,
  output logic          out_valid,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_inst,
  output logic          out_adel,
  input  logic          out_ready,
  output logic [AW:0]   count
);

  if (DEPTH < 2 || DEPTH > 16 || DEPTH != (1 << AW)) begin : g_bad_param
    $error("inst_fetch_queue: DEPTH must be a power of two in 2..16 with AW = log2(DEPTH)");
  end

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } entry_t;

  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic          push;
  logic          pop;
  entry_t        head;

  // Ready/valid come from registered occupancy only, so ID never reaches IF combinationally.
  assign in_ready  = (count_q != FULL_COUNT);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is deliberately left out of reset; the pointers and count define
  // which entries are live and the head outputs are masked when the queue is empty.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= '{pc: in_pc, inst: in_inst, adel: (in_pc[1:0] != 2'b00)};
    end
  end

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    head     = mem[rd_ptr];
    out_pc   = '0;
    out_inst = '0;
    out_adel = 1'b0;
    if (out_valid) begin
      out_pc   = head.pc;
      out_adel = head.adel;
      // A misaligned fetch decodes as NOP so ID raises only the address error.
      out_inst = head.adel ? 32'h0 : head.inst;
    end
  end

  a_count_bound : assert property (@(posedge clk) disable iff (rst) count_q <= FULL_COUNT)
    else $error("inst_fetch_queue: count exceeded DEPTH");

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_inst_fetch_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [31:0]   in_pc = '0;
  logic [31:0]   in_inst = '0;
  logic          in_ready;
  logic          flush = 1'b0;
  logic          out_valid;
  logic [31:0]   out_pc;
  logic [31:0]   out_inst;
  logic          out_adel;
  logic          out_ready = 1'b0;
  logic [AW:0]   count;

  int tests = 0;
  int fails = 0;

  inst_fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
    .in_ready(in_ready), .flush(flush), .out_valid(out_valid), .out_pc(out_pc),
    .out_inst(out_inst), .out_adel(out_adel), .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: an in-order list of accepted words, updated from the handshake rules.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } word_t;
  word_t mq[$];

  always @(posedge clk or posedge rst) begin
    bit do_pop, do_push;
    if (rst || flush) begin
      mq.delete();
    end else begin
      do_pop  = (mq.size() != 0) && out_ready;
      do_push = in_valid && (mq.size() < DEPTH);
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back('{pc: in_pc, inst: in_inst});
    end
  end

  always @(negedge clk) begin
    logic [31:0] e_pc, e_inst;
    logic e_adel;
    if (!rst) begin
      e_pc = 0; e_inst = 0; e_adel = 0;
      if (mq.size() != 0) begin
        e_pc   = mq[0].pc;
        e_adel = (mq[0].pc[1:0] != 2'b00);
        e_inst = e_adel ? 32'h0 : mq[0].inst;
      end
      check("model count",     32'(count),     32'(mq.size()));
      check("model in_ready",  32'(in_ready),  32'(mq.size() < DEPTH));
      check("model out_valid", 32'(out_valid), 32'(mq.size() != 0));
      check("model out_pc",    out_pc,         e_pc);
      check("model out_inst",  out_inst,       e_inst);
      check("model out_adel",  32'(out_adel),  32'(e_adel));
    end
  end

  // Inputs change 2 time units after the rising edge; the task returns at the same point.
  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic fl, input logic ordy);
    in_valid = v; in_pc = pc; in_inst = inst; flush = fl; out_ready = ordy;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12 rst = 1'b0;
    @(posedge clk); #2;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset count", 32'(count), 32'd0);
    check("reset out_pc", out_pc, 32'h0);
    check("reset out_inst", out_inst, 32'h0);

    // Fill to full with ID stalled, then offer a fifth word.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(i * 4), 32'h1000 + 32'(i), 1'b0, 1'b0);
      check("fill count", 32'(count), 32'(i + 1));
    end
    check("full in_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 32'h10, 32'h1010, 1'b0, 1'b0);
    check("full reject count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("drain pc", out_pc, 32'(i * 4));
      check("drain inst", out_inst, 32'h1000 + 32'(i));
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    end
    check("drained out_valid", 32'(out_valid), 32'd0);

    // Streaming: one in, one out per cycle across several pointer wraps.
    drive(1'b1, 32'h0, 32'h2000, 1'b0, 1'b1);
    check("stream start count", 32'(count), 32'd1);
    for (int i = 1; i < 10; i++) begin
      drive(1'b1, 32'(i * 4), 32'h2000 + 32'(i), 1'b0, 1'b1);
      check("stream count", 32'(count), 32'd1);
      check("stream pc", out_pc, 32'(i * 4));
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    check("stream end count", 32'(count), 32'd0);

    // Flush with a simultaneous push.
    drive(1'b1, 32'h100, 32'h3000, 1'b0, 1'b0);
    drive(1'b1, 32'h104, 32'h3004, 1'b0, 1'b0);
    drive(1'b1, 32'h108, 32'h3008, 1'b1, 1'b0);
    check("flush count", 32'(count), 32'd0);
    check("flush out_valid", 32'(out_valid), 32'd0);
    check("flush in_ready", 32'(in_ready), 32'd1);
    drive(1'b1, 32'h200, 32'h4000, 1'b0, 1'b0);
    check("post-flush pc", out_pc, 32'h200);
    check("post-flush inst", out_inst, 32'h4000);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Misaligned fetch.
    drive(1'b1, 32'h42, 32'h8C010000, 1'b0, 1'b0);
    check("adel flag", 32'(out_adel), 32'd1);
    check("adel inst", out_inst, 32'h0);
    check("adel pc", out_pc, 32'h42);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    check("adel drained", 32'(out_adel), 32'd0);

    // Asynchronous reset between edges with three entries held.
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h300 + 32'(i * 4), 32'h5000 + 32'(i), 1'b0, 1'b0);
    check("pre-reset count", 32'(count), 32'd3);
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("async rst count", 32'(count), 32'd0);
    check("async rst out_valid", 32'(out_valid), 32'd0);
    check("async rst in_ready", 32'(in_ready), 32'd1);
    #2 rst = 1'b0;
    @(posedge clk); #2;
    check("post-rst count", 32'(count), 32'd0);
    check("post-rst out_valid", 32'(out_valid), 32'd0);

    // Full with pop: the offered word waits one cycle.
    for (int i = 0; i < 4; i++) drive(1'b1, 32'h400 + 32'(i * 4), 32'h6000 + 32'(i), 1'b0, 1'b0);
    in_valid = 1'b1; in_pc = 32'h410; in_inst = 32'h6004; out_ready = 1'b1;
    #1;
    check("full-pop in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("full-pop count", 32'(count), 32'd3);
    check("full-pop in_ready next", 32'(in_ready), 32'd1);
    check("full-pop head", out_pc, 32'h404);
    drive(1'b1, 32'h410, 32'h6004, 1'b0, 1'b0);
    check("full-pop accept count", 32'(count), 32'd4);
    for (int i = 1; i < 5; i++) begin
      check("full-pop drain pc", out_pc, 32'h400 + 32'(i * 4));
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    end
    check("final empty", 32'(out_valid), 32'd0);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
